router_src_arbiter: RTL and testbench

//  Shares the single byte-wide router input port between NUM_SRC packet sources.

---
 rtl/router_src_if.sv | 25 ++
 rtl/router_src_arbiter.sv | 169 ++++++++++++++++
 tb/tb_router_src_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_src_if.sv
// Source-side bundle between the packet sources and the router input arbiter.
// master = source/router side, slave = arbiter.
interface router_src_if #(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 8
);
  logic [NUM_SRC-1:0]        req;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      busy;
  logic [NUM_SRC-1:0]        gnt;
  logic [NUM_SRC-1:0]        src_adv;
  logic [DATA_W-1:0]         data_out;
  logic                      pkt_valid;
  logic                      abort;

  modport master (
    output req, src_data, busy,
    input  gnt, src_adv, data_out, pkt_valid, abort
  );

  modport slave (
    input  req, src_data, busy,
    output gnt, src_adv, data_out, pkt_valid, abort
  );
endinterface

// File: rtl/router_src_arbiter.sv
// Round-robin, packet-granular arbiter sharing the byte-wide router input port.
// Optional busy watchdog enabled by defining ROUTER_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; pick next requester from rr_ptr upward
// HDR   | granted source presents header byte
// PAY   | payload bytes, counted against header length
// PAR   | parity byte; grant drops after it transfers
module router_src_arbiter #(
  parameter int NUM_SRC        = 3,
  parameter int DATA_W         = 8,
  parameter int LEN_W          = DATA_W - 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        resetn,
  router_src_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 8 || LEN_W != DATA_W - 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("router_src_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, HDR, PAY, PAR} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  data_mux;
  logic [LEN_W-1:0]   hdr_len;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   sel_inc;
  logic               found;
  logic               beat;
  logic               timeout;

  // One-hot grant makes an OR-mux sufficient, and gives 0 when idle.
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt_q[i]) data_mux |= bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  assign hdr_len = data_mux[DATA_W-1:2];
  assign beat    = (state_q != IDLE) && !bus.busy;
  assign sel_inc = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + SEL_W'(1);

  // Two passes: requesters at or above rr_ptr first, then wrap to the low ones.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && bus.req[i] && i >= int'(rr_ptr_q)) begin
        found = 1'b1;
        pick  = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && bus.req[i]) begin
        found = 1'b1;
        pick  = SEL_W'(i);
      end
    end
  end

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int BUSY_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              abort_q;

  assign timeout = (state_q != IDLE) && bus.busy &&
                   (busy_cnt_q == BUSY_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    busy_cnt_d = busy_cnt_q + BUSY_W'(1);
    if (state_q == IDLE || !bus.busy || timeout) busy_cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      abort_q    <= timeout;
    end
  end

  assign bus.abort = abort_q;
`else
  assign timeout   = 1'b0;
  assign bus.abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NUM_SRC'(1) << pick;
          sel_d   = pick;
          state_d = HDR;
        end
      end
      HDR: begin
        if (beat) begin
          len_d   = hdr_len;
          cnt_d   = '0;
          state_d = (hdr_len == '0) ? PAR : PAY;
        end
      end
      PAY: begin
        // Compare precedes the increment, so cnt tops out at len and never wraps.
        if (beat) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = PAR;
        end
      end
      PAR: begin
        if (beat) begin
          gnt_d    = '0;
          rr_ptr_d = sel_inc;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      gnt_d    = '0;
      rr_ptr_d = sel_inc;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.src_adv   = gnt_q & {NUM_SRC{beat}};
  assign bus.data_out  = data_mux;
  assign bus.pkt_valid = (state_q == HDR) || (state_q == PAY);
endmodule

// File: tb/tb_router_src_arbiter.sv
// Randomized bench for router_src_arbiter: sources hold whole packets, a packet-level
// model predicts grant owner, beat progress and the byte on the router port.
module tb_router_src_arbiter;
  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 6;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_src_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();

  router_src_arbiter #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(255)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Source side: each source holds one packet (header, payload, parity) and a read position.
  logic [7:0] pkt [NUM_SRC][66];
  int         plen    [NUM_SRC];
  int         pos     [NUM_SRC];
  int         gap     [NUM_SRC];
  bit         has_pkt [NUM_SRC];

  // Model: who owns the port, how many beats of its packet have transferred, rr pointer.
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;

  int busy_pct   = 0;
  int stall_left = 0;
  int len_max    = 4;
  bit long_ok    = 0;
  bit reload     = 0;
  bit drop_ok    = 0;
  bit rst_now    = 0;
  int pv_cycles  = 0;
  int gnt_cycles = 0;
  int grant_log[$];
  logic [NUM_SRC-1:0] prev_gnt = '0;

  task automatic new_pkt(input int s, input int len, input int addr);
    logic [5:0] l6;
    logic [1:0] a2;
    logic [7:0] par;
    l6 = 6'(len);
    a2 = 2'(addr);
    pkt[s][0] = {l6, a2};
    par = pkt[s][0];
    for (int i = 1; i <= len; i++) begin
      pkt[s][i] = 8'($urandom);
      par ^= pkt[s][i];
    end
    pkt[s][len+1] = par;
    plen[s]    = len;
    pos[s]     = 0;
    has_pkt[s] = 1'b1;
  endtask

  function automatic int rand_len();
    if (long_ok && $urandom_range(15) == 0) return 63;
    return int'($urandom_range(len_max));
  endfunction

  task automatic step();
    logic [NUM_SRC-1:0] exp_gnt;
    logic [7:0]         exp_data;
    bit                 exp_pv;
    int                 o;
    @(negedge clock);
    resetn  = !rst_now;
    rst_now = 1'b0;
    if (stall_left > 0) begin
      bus.busy = 1'b1;
      stall_left--;
    end else begin
      bus.busy = ($urandom_range(99) < busy_pct);
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      bus.req[s] = has_pkt[s];
      if (drop_ok && s == m_owner && $urandom_range(1) == 1) bus.req[s] = 1'b0;
      bus.src_data[s*DATA_W +: DATA_W] = has_pkt[s] ? pkt[s][pos[s]] : 8'($urandom);
    end
    #1;
    exp_gnt  = '0;
    exp_data = '0;
    exp_pv   = 1'b0;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_data = pkt[m_owner][pos[m_owner]];
      exp_pv   = (m_beats < plen[m_owner] + 1);
    end
    check("gnt", bus.gnt, exp_gnt);
    check("pkt_valid", bus.pkt_valid, exp_pv);
    check("data_out", bus.data_out, exp_data);
    check("src_adv", bus.src_adv, bus.busy ? '0 : exp_gnt);
    check("abort", bus.abort, 0);
    if (bus.gnt != '0 && prev_gnt == '0) begin
      for (int s = 0; s < NUM_SRC; s++) if (bus.gnt[s]) grant_log.push_back(s);
    end
    prev_gnt = bus.gnt;
    if (bus.pkt_valid) pv_cycles++;
    if (bus.gnt != '0) gnt_cycles++;

    @(posedge clock);
    if (!resetn) begin
      m_owner = -1;
      m_rr    = 0;
      for (int s = 0; s < NUM_SRC; s++) pos[s] = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (m_owner < 0 && bus.req[(m_rr + k) % NUM_SRC]) begin
          m_owner = (m_rr + k) % NUM_SRC;
          m_beats = 0;
        end
      end
    end else if (!bus.busy) begin
      o = m_owner;
      pos[o]++;
      m_beats++;
      if (m_beats == plen[o] + 2) begin
        has_pkt[o] = 1'b0;
        gap[o]     = int'($urandom_range(3));
        m_rr       = (o + 1) % NUM_SRC;
        m_owner    = -1;
      end
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (reload && !has_pkt[s]) begin
        if (gap[s] == 0) new_pkt(s, rand_len(), int'($urandom_range(3)));
        else gap[s]--;
      end
    end
  endtask

  function automatic bit in_pay();
    return m_owner >= 0 && m_beats >= 1 && m_beats < plen[m_owner] + 1;
  endfunction

  task automatic wait_pay(input string tag);
    for (int c = 0; c < 400 && !in_pay(); c++) step();
    check(tag, in_pay(), 1);
  endtask

  task automatic run_until_idle(input string tag);
    bit pending;
    for (int c = 0; c < 200; c++) begin
      pending = (m_owner >= 0);
      for (int s = 0; s < NUM_SRC; s++) if (has_pkt[s]) pending = 1'b1;
      if (!pending) break;
      step();
    end
    check(tag, (m_owner >= 0), 0);
  endtask

  initial begin
    for (int s = 0; s < NUM_SRC; s++) begin
      has_pkt[s] = 1'b0;
      gap[s]     = 0;
      plen[s]    = 0;
      pos[s]     = 0;
    end
    resetn       = 1'b0;
    bus.req      = '0;
    bus.busy     = 1'b0;
    bus.src_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_pv", bus.pkt_valid, 0);
    check("rst_adv", bus.src_adv, 0);
    check("rst_abort", bus.abort, 0);

    // Single source, header 0x0D: 4 valid beats then parity, grant held 5 cycles.
    new_pkt(0, 3, 1);
    pv_cycles  = 0;
    gnt_cycles = 0;
    run_until_idle("t1_done");
    check("t1_pv_cycles", pv_cycles, 4);
    check("t1_gnt_cycles", gnt_cycles, 5);

    // Contention from reset: round-robin order 0,1,2,0.
    rst_now = 1'b1;
    step();
    for (int s = 0; s < NUM_SRC; s++) new_pkt(s, int'($urandom_range(4)), s);
    grant_log.delete();
    reload  = 1'b1;
    len_max = 4;
    for (int c = 0; c < 200 && grant_log.size() < 4; c++) step();
    check("t2_ngrants", (grant_log.size() >= 4), 1);
    if (grant_log.size() >= 4) begin
      check("t2_order0", grant_log[0], 0);
      check("t2_order1", grant_log[1], 1);
      check("t2_order2", grant_log[2], 2);
      check("t2_order3", grant_log[3], 0);
    end

    // Four-cycle stall inside the payload.
    len_max = 6;
    wait_pay("t3_reach_pay");
    stall_left = 4;
    repeat (60) step();

    // Zero-length packet: header then parity, 2 beats.
    reload = 1'b0;
    run_until_idle("t4_drain");
    new_pkt(1, 0, 2);
    pv_cycles  = 0;
    gnt_cycles = 0;
    run_until_idle("t4_done");
    check("t4_pv_cycles", pv_cycles, 1);
    check("t4_gnt_cycles", gnt_cycles, 2);

    // Reset mid-payload, then normal service resumes.
    reload  = 1'b1;
    len_max = 8;
    wait_pay("t5_reach_pay");
    rst_now = 1'b1;
    step();
    #1;
    check("t5_gnt_after_rst", bus.gnt, 0);
    check("t5_data_after_rst", bus.data_out, 0);
    check("t5_pv_after_rst", bus.pkt_valid, 0);
    repeat (100) step();

    // Soak: random busy, random lengths including maximum, requests dropped after grant.
    busy_pct = 30;
    long_ok  = 1'b1;
    drop_ok  = 1'b1;
    len_max  = 10;
    repeat (4000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
